seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits.
- Accepts a packed word of BCD/hex nibbles and decodes one digit at a time. Each digit is scanned for a programmable slot length.
- Adds double-buffered update, leading-zero suppression, per-digit blink and inter-digit dead time.
- Sits between the datapath/counter logic and the board's segment and digit-select pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 1000, clock cycles per digit slot (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
HEX_MODE, 0, 1: values 10-15 show A,b,C,d,E,F; 0: values 10-15 are blanked
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit
DIG_ACTIVE_LOW, 1, 1: digit_sel driven low = selected

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  1: display on; 0: all outputs inactive, counters keep running
load  in  1  single-cycle strobe capturing digits_in/dp_in
digits_in  in  4*NUM_DIGITS  nibble i = digit i; digit 0 = least significant, bits [3:0]
dp_in  in  NUM_DIGITS  decimal point per digit
lz_blank  in  1  enable leading-zero suppression
blink_mask  in  NUM_DIGITS  1: digit blinks
seg  out  7  segments {A,B,C,D,E,F,G}, A = bit 6
dp  out  1  decimal point of the selected digit
digit_sel  out  NUM_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on rst_n, sampled only on the rising clk edge.
- Reset state:
  - prescaler=0, digit index=0.
  - active and pending buffers=0, pending_valid=0, blink frame counter=0, blink_phase=0.
  - seg, dp and digit_sel all at their inactive levels; frame_done=0.
  - Reset asserted mid-frame takes effect on the next edge and discards pending data.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→…→NUM_DIGITS-1→0.
- Frame end: the prescaler terminal count while the index is NUM_DIGITS-1. One cycle later, frame_done=1 for exactly 1 cycle.
- Double buffer:
  - load=1 writes digits_in/dp_in into pending and sets pending_valid. A repeated load overwrites pending.
  - At frame end, pending is copied to active if pending_valid=1, and pending_valid is cleared.
  - If load coincides with frame end, digits_in/dp_in go directly to active and pending_valid ends cleared.
- Decode, active-high form A..G:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Blank = 0000000.
  - Inverted on the pin when SEG_ACTIVE_LOW=1.
- Leading-zero suppression (lz_blank=1): digit i (i>0) is blanked when its nibble and all higher nibbles are 0. Digit 0 is never suppressed. dp of a suppressed digit is still shown if set.
- Blink:
  - blink_phase toggles every BLINK_FRAMES frame ends.
  - When blink_phase=1, digits with blink_mask=1 show blank and dp off.
- Dead time: while prescaler==0, seg/dp are inactive while digit_sel already selects the new digit. This gives a 1-cycle anti-ghosting gap per slot.
- Output timing and gating:
  - All outputs are registered, so they lag the index/prescaler state by 1 cycle.
  - digit_sel is one-hot for the current index, polarity per DIG_ACTIVE_LOW.
  - enable=0 forces seg, dp and digit_sel inactive within 1 cycle. Scan, buffer and blink state continue to update.
  - frame_done is not gated by enable.

Test Plan:
- Reset: with NUM_DIGITS=4 and defaults, hold rst_n=0 for 3 cycles → seg=7'b1111111, dp=1, digit_sel=4'b1111, frame_done=0. After release, the first selection is digit_sel=4'b1110.
- Scan order: SCAN_DIV=4, load digits_in=16'h4321 → after the first frame end, successive slots show seg=~1111110 style codes for 1,2,3,4 (e.g. digit 0: seg=~7'b0110000). Each slot lasts 4 cycles with cycle 0 blank, and frame_done pulses every 16 cycles.
- Double buffer: load 16'h1234, then load 16'h5678 mid-frame → no change until frame end, then the active value becomes 5678. Load coinciding with frame end → the new value is active immediately.
- Leading-zero: digits_in=16'h0050, lz_blank=1 → digits 3 and 2 are blank, digit 1 shows 5, digit 0 shows 0. Test 16'h0000 → only digit 0 lit.
- Blink and HEX: HEX_MODE=1, BLINK_FRAMES=2, digits_in=16'h00AF, blink_mask=4'b0001 → digit 0 alternates F / blank every 2 frames and digit 1 steadily shows A. With HEX_MODE=0, both A and F are blank.
- Enable: deassert enable mid-slot → next cycle all outputs are inactive. Reassert → display resumes at the current index with no counter reset.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment scan driver with double buffer, blink and LZ blanking
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_end;

    // Active-high glyph for one nibble; 10-15 only render in hex mode.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (HEX_MODE == 0 && v > 4'h9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    // Slot prescaler and digit index; frame ends on the last slot's terminal count.
    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            frame_end = (idx_q == IDX_LAST);
            idx_d     = frame_end ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Double buffer: loads land in pending; frame end promotes (a coincident load bypasses pending).
    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_valid_d  = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                act_digits_d = digits_in;
                act_dp_d     = dp_in;
            end else if (pend_valid_q) begin
                act_digits_d = pend_digits_q;
                act_dp_d     = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Blink phase flips after every BLINK_FRAMES frame ends.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Output pattern for the current slot: LZ blanking, blink, dead time and enable gating.
    always_comb begin
        logic [3:0]            cur_nib;
        logic                  cur_dp;
        logic                  cur_blink;
        logic                  cur_sup;
        logic                  zero_above;
        logic [NUM_DIGITS-1:0] sel_onehot;
        logic [6:0]            pat;
        logic                  lit_dp;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_sup    = 1'b0;
        zero_above = 1'b1;
        sel_onehot = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_digits_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = act_digits_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_blink     = blink_mask[i];
                cur_sup       = lz_blank && (i != 0) && zero_above;
                sel_onehot[i] = 1'b1;
            end
        end
        pat    = decode(cur_nib);
        lit_dp = cur_dp;
        if (blink_phase_q && cur_blink) begin
            pat    = 7'b0000000;
            lit_dp = 1'b0;
        end else if (cur_sup) begin
            pat = 7'b0000000;
        end
        if (!enable || presc_q == '0) begin
            pat    = 7'b0000000;
            lit_dp = 1'b0;
        end
        seg_d        = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        dp_d         = (SEG_ACTIVE_LOW != 0) ? ~lit_dp : lit_dp;
        digit_sel_d  = !enable ? SEL_OFF :
                       ((DIG_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot);
        frame_done_d = frame_end;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            digit_sel_q   <= SEL_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_sel_q   <= digit_sel_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = SD * ND;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, load, lz_blank;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, blink_mask;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, fd0, fd1;
    logic [3:0] sel0, sel1;

    // Hex decode, active-low segments and digit selects.
    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(1),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_hex_al (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .lz_blank(lz_blank), .blink_mask(blink_mask),
        .seg(seg0), .dp(dp0), .digit_sel(sel0), .frame_done(fd0));

    // Decimal-only decode, active-high segments and digit selects.
    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_MODE(0),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dec_ah (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .lz_blank(lz_blank), .blink_mask(blink_mask),
        .seg(seg1), .dp(dp1), .digit_sel(sel1), .frame_done(fd1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time since reset, buffer contents and number of completed frames.
    int          m_k, m_frames;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_actdp, m_penddp;
    bit          m_pv;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_fd;
    logic [3:0]  e_sel0, e_sel1;

    function automatic logic [6:0] glyph(input int v, input bit hex);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            10: return hex ? 7'b1110111 : 7'b0000000;
            11: return hex ? 7'b0011111 : 7'b0000000;
            12: return hex ? 7'b1001110 : 7'b0000000;
            13: return hex ? 7'b0111101 : 7'b0000000;
            14: return hex ? 7'b1001111 : 7'b0000000;
            default: return hex ? 7'b1000111 : 7'b0000000;
        endcase
    endfunction

    task automatic model_step();
        int          slot_pos, idx;
        bit          fe, phase;
        logic [15:0] upper;
        logic [6:0]  p0, p1;
        logic        dpv;
        if (!rst_n) begin
            m_k = 0; m_frames = 0; m_act = 0; m_pend = 0; m_actdp = 0; m_penddp = 0; m_pv = 0;
            e_seg0 = 7'h7F; e_dp0 = 1'b1; e_sel0 = 4'hF;
            e_seg1 = 7'h00; e_dp1 = 1'b0; e_sel1 = 4'h0;
            e_fd = 1'b0;
            return;
        end
        slot_pos = m_k % SD;
        idx      = (m_k / SD) % ND;
        fe       = (m_k % FRAME) == FRAME - 1;
        phase    = ((m_frames / BF) % 2) == 1;
        upper    = m_act >> (4 * idx);
        if (phase && blink_mask[idx]) begin
            p0 = 0; p1 = 0; dpv = 0;
        end else if (lz_blank && idx > 0 && upper == 16'h0) begin
            p0 = 0; p1 = 0; dpv = m_actdp[idx];
        end else begin
            p0 = glyph(int'(upper[3:0]), 1'b1);
            p1 = glyph(int'(upper[3:0]), 1'b0);
            dpv = m_actdp[idx];
        end
        if (!enable || slot_pos == 0) begin
            p0 = 0; p1 = 0; dpv = 0;
        end
        e_seg0 = ~p0; e_dp0 = ~dpv;
        e_seg1 = p1;  e_dp1 = dpv;
        e_sel0 = enable ? ~(4'b0001 << idx) : 4'hF;
        e_sel1 = enable ? (4'b0001 << idx) : 4'h0;
        e_fd   = fe;
        if (load) begin
            m_pend = digits_in; m_penddp = dp_in; m_pv = 1;
        end
        if (fe) begin
            if (load) begin
                m_act = digits_in; m_actdp = dp_in;
            end else if (m_pv) begin
                m_act = m_pend; m_actdp = m_penddp;
            end
            m_pv = 0;
            m_frames++;
        end
        m_k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("seg_hex_al", 32'(seg0), 32'(e_seg0));
        chk("dp_hex_al",  32'(dp0),  32'(e_dp0));
        chk("sel_hex_al", 32'(sel0), 32'(e_sel0));
        chk("fd_hex_al",  32'(fd0),  32'(e_fd));
        chk("seg_dec_ah", 32'(seg1), 32'(e_seg1));
        chk("dp_dec_ah",  32'(dp1),  32'(e_dp1));
        chk("sel_dec_ah", 32'(sel1), 32'(e_sel1));
        chk("fd_dec_ah",  32'(fd1),  32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d; dp_in = p; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    // Advance until the next cycle is a frame end (bounded by one frame).
    task automatic to_frame_end();
        for (int i = 0; i < FRAME && (m_k % FRAME) != FRAME - 1; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0; lz_blank = 1'b0;
        digits_in = 16'h0; dp_in = 4'h0; blink_mask = 4'h0;

        // Reset held for three cycles.
        run(3);
        chk("rst_seg", 32'(seg0), 32'(7'b1111111));
        chk("rst_dp",  32'(dp0),  32'(1'b1));
        chk("rst_sel", 32'(sel0), 32'(4'b1111));
        chk("rst_fd",  32'(fd0),  32'(1'b0));
        rst_n = 1'b1;
        cycle();
        chk("first_sel", 32'(sel0), 32'(4'b1110));
        chk("first_seg_dead", 32'(seg0), 32'(7'b1111111));

        // Scan order with 4321 promoted at the first frame end.
        do_load(16'h4321, 4'b0100);
        run(3 * FRAME);

        // Double buffer: second load overwrites pending mid-frame.
        do_load(16'h1234, 4'h0);
        run(5);
        do_load(16'h5678, 4'h1);
        run(2 * FRAME);

        // Load coinciding with frame end goes straight to active.
        to_frame_end();
        do_load(16'h9087, 4'h8);
        run(FRAME);

        // Leading-zero suppression, including a dp on a suppressed digit.
        lz_blank = 1'b1;
        do_load(16'h0050, 4'h0);
        run(2 * FRAME);
        do_load(16'h0000, 4'b1000);
        run(2 * FRAME);
        lz_blank = 1'b0;

        // Blink and hex glyphs: digit 0 blinks F, digit 1 shows A steadily.
        blink_mask = 4'b0001;
        do_load(16'h00AF, 4'h0);
        run(9 * FRAME);
        blink_mask = 4'h0;

        // Enable drop mid-slot and resume without counter reset.
        run(2);
        enable = 1'b0;
        cycle();
        chk("dis_sel", 32'(sel0), 32'(4'b1111));
        chk("dis_seg", 32'(seg0), 32'(7'b1111111));
        run(5);
        enable = 1'b1;
        run(FRAME);

        // Reset mid-frame discards pending data.
        do_load(16'h9999, 4'hF);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        run(2 * FRAME);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < ND; n++)
                digits_in[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            dp_in      = 4'($urandom_range(0, 15));
            load       = ($urandom_range(0, 9) == 0);
            enable     = ($urandom_range(0, 7) != 0);
            lz_blank   = ($urandom_range(0, 1) == 1);
            blink_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : blink_mask;
            rst_n      = ($urandom_range(0, 499) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
